// File: rtl/pcs_rx_block_lock.sv
// 64b/66b receive block-lock controller. It checks each 2-bit sync header and
// asks the gearbox to slip one bit until headers line up. It gates decoder
// input valid on lock and keeps a saturating slip counter.
module pcs_rx_block_lock #(
  parameter int          SH_CNT_MAX       = 64,
  parameter int          SH_INVALID_MAX   = 16,
  parameter int          SLIP_WAIT_CYCLES = 4,
  parameter logic [15:0] SLIP_COUNT_MAX   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  in_header,
  input  logic        in_header_valid,
  output logic        out_slip,
  output logic        out_block_lock,
  output logic        out_decoder_valid,
  output logic [15:0] out_slip_count
);

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVALID_MAX + 1);
  localparam int WW = (SLIP_WAIT_CYCLES > 1) ? $clog2(SLIP_WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {ST_TEST, ST_SLIP, ST_WAIT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   sh_cnt, sh_cnt_n, cnt_inc;
  logic [IW-1:0]   sh_inv, sh_inv_n, inv_inc;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic            lock, lock_n;
  logic [15:0]     slip_count, slip_count_n;
  logic            hdr_bad;

  // 00 and 11 carry no transition and cannot be a real sync header
  assign hdr_bad = ~(in_header[1] ^ in_header[0]);
  assign cnt_inc = sh_cnt + 1'b1;
  assign inv_inc = sh_inv + {{(IW-1){1'b0}}, hdr_bad};

  // Register state, window counters, lock and slip count
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_TEST;
      sh_cnt     <= '0;
      sh_inv     <= '0;
      wait_cnt   <= '0;
      lock       <= 1'b0;
      slip_count <= '0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_cnt_n;
      sh_inv     <= sh_inv_n;
      wait_cnt   <= wait_n;
      lock       <= lock_n;
      slip_count <= slip_count_n;
    end
  end

  // Next-state: a slip decision takes priority over closing a window
  always_comb begin
    state_n      = state;
    sh_cnt_n     = sh_cnt;
    sh_inv_n     = sh_inv;
    wait_n       = wait_cnt;
    lock_n       = lock;
    slip_count_n = slip_count;
    case (state)
      ST_TEST: begin
        if (in_header_valid) begin
          sh_cnt_n = cnt_inc;
          sh_inv_n = inv_inc;
          if ((!lock && hdr_bad) || (lock && (inv_inc == IW'(SH_INVALID_MAX)))) begin
            state_n  = ST_SLIP;
            lock_n   = 1'b0;
            sh_cnt_n = '0;
            sh_inv_n = '0;
            // Counted on entry so the count is visible alongside the pulse
            if (slip_count != SLIP_COUNT_MAX)
              slip_count_n = slip_count + 16'd1;
          end else if (cnt_inc == CW'(SH_CNT_MAX)) begin
            lock_n   = 1'b1;
            sh_cnt_n = '0;
            sh_inv_n = '0;
          end
        end
      end
      ST_SLIP: begin
        state_n  = ST_WAIT;
        wait_n   = '0;
        lock_n   = 1'b0;
        sh_cnt_n = '0;
        sh_inv_n = '0;
      end
      ST_WAIT: begin
        // Headers are ignored while the gearbox settles
        sh_cnt_n = '0;
        sh_inv_n = '0;
        if (wait_cnt == WW'(SLIP_WAIT_CYCLES - 1))
          state_n = ST_TEST;
        else
          wait_n = wait_cnt + 1'b1;
      end
      default: state_n = ST_TEST;
    endcase
  end

  assign out_slip          = (state == ST_SLIP);
  assign out_block_lock    = lock;
  assign out_decoder_valid = in_header_valid & lock;
  assign out_slip_count    = slip_count;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Randomised bench for pcs_rx_block_lock against a window/blind-period model.
module tb_pcs_rx_block_lock;

  localparam int WAITC = 4;
  localparam int NWIN  = 64;
  localparam int NINV  = 16;
  localparam int SAT   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  in_header = 2'b01;
  logic        in_header_valid = 1'b0;
  logic        out_slip, out_block_lock, out_decoder_valid;
  logic [15:0] out_slip_count;

  pcs_rx_block_lock #(
    .SH_CNT_MAX(NWIN), .SH_INVALID_MAX(NINV), .SLIP_WAIT_CYCLES(WAITC),
    .SLIP_COUNT_MAX(16'(SAT))
  ) dut (
    .clk(clk), .rst(rst), .in_header(in_header), .in_header_valid(in_header_valid),
    .out_slip(out_slip), .out_block_lock(out_block_lock),
    .out_decoder_valid(out_decoder_valid), .out_slip_count(out_slip_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: headers-in-window, bad-in-window, and a count of cycles
  // during which headers are ignored after a slip (the slip cycle + wait).
  bit m_lock, m_pulse;
  int m_win, m_bad, m_blind, m_slips;
  int cyc_no = 0;
  int pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic bit is_bad(input logic [1:0] h);
    return (h == 2'b00) || (h == 2'b11);
  endfunction

  function automatic logic [1:0] good_hdr(input int i);
    return (i % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [1:0] h);
    m_pulse = 0;
    if (r) begin
      m_lock = 0; m_win = 0; m_bad = 0; m_blind = 0; m_slips = 0;
    end else if (m_blind > 0) begin
      m_blind--;
    end else if (v) begin
      m_win++;
      if (is_bad(h)) m_bad++;
      if ((!m_lock && is_bad(h)) || (m_lock && m_bad == NINV)) begin
        m_lock = 0; m_win = 0; m_bad = 0;
        m_blind = 1 + WAITC;
        m_pulse = 1;
        if (m_slips < SAT) m_slips++;
      end else if (m_win == NWIN) begin
        m_lock = 1; m_win = 0; m_bad = 0;
      end
    end
  endtask

  // One clock: drive, check combinational valid, clock, check registered outputs
  task automatic cyc(input logic r, input logic v, input logic [1:0] h);
    rst = r; in_header_valid = v; in_header = h;
    #1;
    chk("dec_valid", {31'd0, out_decoder_valid}, {31'd0, v & m_lock});
    @(posedge clk);
    model_step(r, v, h);
    cyc_no++;
    #1;
    chk("slip", {31'd0, out_slip}, {31'd0, m_pulse});
    chk("lock", {31'd0, out_block_lock}, {31'd0, m_lock});
    chk("slip_count", {16'd0, out_slip_count}, m_slips);
    if (out_slip) pulse_cnt++;
  endtask

  task automatic good_run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, good_hdr(i));
  endtask

  // A full 64-header window with nbad invalid headers at random positions
  task automatic bad_window(input int nbad);
    int pos[NWIN];
    bit mark[NWIN];
    for (int i = 0; i < NWIN; i++) begin pos[i] = i; mark[i] = 0; end
    for (int i = NWIN - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = pos[i]; pos[i] = pos[j]; pos[j] = t;
    end
    for (int i = 0; i < nbad; i++) mark[pos[i]] = 1;
    for (int i = 0; i < NWIN; i++)
      cyc(0, 1, mark[i] ? (($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11) : good_hdr(i));
  endtask

  initial begin
    int c0, p0, last;
    m_lock = 0; m_win = 0; m_bad = 0; m_blind = 0; m_slips = 0; m_pulse = 0;

    // T1: reset then 64 good headers
    cyc(1, 0, 2'b01);
    cyc(1, 0, 2'b01);
    chk("rst_slip", {31'd0, out_slip}, 0);
    chk("rst_lock", {31'd0, out_block_lock}, 0);
    chk("rst_count", {16'd0, out_slip_count}, 0);
    p0 = pulse_cnt;
    good_run(NWIN - 1);
    chk("t1_lock_early", {31'd0, out_block_lock}, 0);
    cyc(0, 1, 2'b10);
    chk("t1_lock", {31'd0, out_block_lock}, 1);
    chk("t1_no_slip", pulse_cnt - p0, 0);

    // T2: bad header on the 10th while unlocked
    cyc(1, 0, 2'b01);
    good_run(9);
    cyc(0, 1, 2'b00);
    chk("t2_pulse", {31'd0, out_slip}, 1);
    chk("t2_count", {16'd0, out_slip_count}, 1);
    for (int i = 0; i < 1 + WAITC; i++) cyc(0, 1, 2'b11);  // ignored
    chk("t2_one_pulse", {16'd0, out_slip_count}, 1);
    good_run(NWIN);
    chk("t2_relock", {31'd0, out_block_lock}, 1);

    // T3: 15 bad holds lock, 16 bad breaks it
    bad_window(NINV - 1);
    chk("t3_hold", {31'd0, out_block_lock}, 1);
    c0 = out_slip_count; p0 = pulse_cnt;
    bad_window(NINV);
    chk("t3_unlock", {31'd0, out_block_lock}, 0);
    chk("t3_pulses", pulse_cnt - p0, 1);
    chk("t3_count", {16'd0, out_slip_count}, c0 + 1);

    // T4: valid toggling while locked, then while unlocked
    good_run(NWIN);
    for (int i = 0; i < 40; i++) cyc(0, $urandom_range(1, 0), good_hdr(i));
    cyc(1, 0, 2'b01);
    for (int i = 0; i < 20; i++) cyc(0, $urandom_range(1, 0), good_hdr(i));

    // T5: reset mid-window while locked
    good_run(NWIN + 20);
    cyc(1, 1, 2'b01);
    chk("t5_slip", {31'd0, out_slip}, 0);
    chk("t5_lock", {31'd0, out_block_lock}, 0);
    chk("t5_count", {16'd0, out_slip_count}, 0);
    good_run(NWIN - 1);
    chk("t5_not_yet", {31'd0, out_block_lock}, 0);
    cyc(0, 1, 2'b01);
    chk("t5_relock", {31'd0, out_block_lock}, 1);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] h;
      h = ($urandom_range(59, 0) == 0) ? 2'(($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11)
                                       : good_hdr(i);
      cyc($urandom_range(599, 0) == 0, $urandom_range(3, 0) != 0, h);
    end

    // T6: continuous 11 headers: periodic slips and saturation
    cyc(1, 0, 2'b01);
    last = -1;
    for (int i = 0; i < (SAT + 5) * (2 + WAITC); i++) begin
      cyc(0, 1, 2'b11);
      if (out_slip) begin
        if (last >= 0) chk("t6_period", cyc_no - last, 2 + WAITC);
        last = cyc_no;
      end
    end
    chk("t6_saturate", {16'd0, out_slip_count}, SAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
